// File: rtl/core_boot_sequencer.sv
// core_boot_sequencer: streams a program image into the core over ISP,
// then holds reset, pulses start and times the run until halt or timeout.
module core_boot_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_BITS   = 12,
    parameter int unsigned RESET_CYCLES   = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   host_data,
    input  logic                    host_valid,
    output logic                    host_ready,
    output logic                    isp_write,
    output logic [ADDRESS_BITS-1:0] isp_address,
    output logic [DATA_WIDTH-1:0]   isp_data,
    output logic                    core_reset,
    output logic                    core_start,
    output logic [19:0]             prog_address,
    input  logic                    halt_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    timed_out,
    output logic                    error,
    output logic [31:0]             cycle_count
);

    localparam logic [DATA_WIDTH-1:0] MEM_WORDS =
        DATA_WIDTH'(64'd1 << ADDRESS_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOAD, S_RST_HOLD, S_START, S_RUN, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    wr_q, wr_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    creset_q, creset_d;
    logic                    start_q, start_d;
    logic [19:0]             paddr_q, paddr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tout_q, tout_d;
    logic                    err_q, err_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             hold_q, hold_d;
    logic [ADDRESS_BITS:0]   len_q, len_d;
    logic [ADDRESS_BITS:0]   idx_q, idx_d;
    logic [ADDRESS_BITS-1:0] base_q, base_d;

    logic hs;
    logic len_bad;

    assign hs      = host_valid && ready_q;
    assign len_bad = (host_data == '0) || (host_data > MEM_WORDS);

    always_comb begin
        state_d  = state_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        creset_d = creset_q;
        paddr_d  = paddr_q;
        tout_d   = tout_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        len_d    = len_q;
        idx_d    = idx_q;
        base_d   = base_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (hs) begin
                    len_d    = host_data[ADDRESS_BITS:0];
                    tout_d   = 1'b0;
                    err_d    = len_bad;
                    creset_d = 1'b1;
                    state_d  = len_bad ? S_DONE : S_HDR;
                end
            end
            S_HDR: begin
                if (hs) begin
                    paddr_d = host_data[19:0];
                    base_d  = host_data[ADDRESS_BITS+1:2];
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    wr_d   = 1'b1;
                    addr_d = base_q + idx_q[ADDRESS_BITS-1:0];
                    data_d = host_data;
                    idx_d  = idx_q + (ADDRESS_BITS+1)'(1);
                    if (idx_d == len_q) begin
                        hold_d  = '0;
                        state_d = S_RST_HOLD;
                    end
                end
            end
            S_RST_HOLD: begin
                if (hold_q == 32'(RESET_CYCLES)) begin
                    state_d = S_START;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                // halt has priority over a coincident timeout
                if (halt_valid) begin
                    state_d = S_DONE;
                end else if (cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = state_d inside {S_IDLE, S_HDR, S_LOAD, S_DONE};
        busy_d  = !(state_d inside {S_IDLE, S_DONE});
        done_d  = (state_d == S_DONE);
        start_d = (state_d == S_START);
        if (state_d == S_START) begin
            creset_d = 1'b0;
            cnt_d    = '0;
        end
        if (state_d == S_RUN) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            creset_q <= 1'b1;
            start_q  <= 1'b0;
            paddr_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            hold_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            creset_q <= creset_d;
            start_q  <= start_d;
            paddr_q  <= paddr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
        end
    end

    assign host_ready   = ready_q;
    assign isp_write    = wr_q;
    assign isp_address  = addr_q;
    assign isp_data     = data_q;
    assign core_reset   = creset_q;
    assign core_start   = start_q;
    assign prog_address = paddr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timed_out    = tout_q;
    assign error        = err_q;
    assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb_core_boot_sequencer: directed runs checked every cycle against a
// word-level model of the boot stream, plus literal end-of-run values.
module tb_core_boot_sequencer;

    localparam int RST = 10;
    localparam int TMO = 50;
    localparam int M_LEN  = 0;
    localparam int M_HDR  = 1;
    localparam int M_DATA = 2;
    localparam int M_WAIT = 3;

    logic        clock;
    logic        reset;
    logic [31:0] host_data;
    logic        host_valid;
    logic        host_ready;
    logic        isp_write;
    logic [11:0] isp_address;
    logic [31:0] isp_data;
    logic        core_reset;
    logic        core_start;
    logic [19:0] prog_address;
    logic        halt_valid;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic        error;
    logic [31:0] cycle_count;

    core_boot_sequencer #(
        .DATA_WIDTH(32), .ADDRESS_BITS(12),
        .RESET_CYCLES(RST), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .host_data(host_data), .host_valid(host_valid),
        .host_ready(host_ready), .isp_write(isp_write),
        .isp_address(isp_address), .isp_data(isp_data),
        .core_reset(core_reset), .core_start(core_start),
        .prog_address(prog_address), .halt_valid(halt_valid),
        .busy(busy), .done(done), .timed_out(timed_out),
        .error(error), .cycle_count(cycle_count)
    );

    typedef struct {
        int          cyc;
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    wr_t         expq[$];
    logic [11:0] wr_log[$];
    int          phase = M_LEN;
    int          lenm, idxm, basem;
    int          exp_start = -1;
    int          exp_done = -1;
    int          exp_cnt = 0;
    logic        exp_to = 0;
    logic        exp_err = 0;
    logic [19:0] exp_pa = 0;
    logic        rst_chk = 0;
    int          last_wr = 0;
    int          seen_start = 0;

    initial clock = 0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        logic ew, dn;
        if (cyc >= 1) begin
            if (rst_chk) begin
                chk("reset_ctl",
                    64'({host_ready, isp_write, core_reset, core_start,
                         busy, done, timed_out, error,
                         isp_address, prog_address}),
                    64'({8'b0010_0000, 32'h0}));
                chk("reset_dat", {isp_data, cycle_count}, 64'h0);
            end
            ew = (expq.size() > 0) && (expq[0].cyc == cyc);
            chk("isp_write", 64'(isp_write), 64'(ew));
            if (ew) begin
                if (isp_write) begin
                    chk("isp_addr", 64'(isp_address), 64'(expq[0].a));
                    chk("isp_data", 64'(isp_data), 64'(expq[0].d));
                end
                expq.delete(0);
            end
            if (isp_write) begin
                wr_log.push_back(isp_address);
                last_wr = cyc;
            end
            if (core_start) seen_start = cyc;
            dn = (exp_done >= 0) && (cyc >= exp_done);
            chk("done", 64'(done), 64'(dn));
            chk("core_start", 64'(core_start),
                64'(exp_start >= 0 && cyc == exp_start));
            chk("core_reset", 64'(core_reset),
                64'(!(exp_start >= 0 && cyc >= exp_start)));
            chk("busy", 64'(busy), 64'(phase != M_LEN && !dn));
            if (dn) begin
                chk("ready_done", 64'(host_ready), 64'd1);
                chk("error", 64'(error), 64'(exp_err));
                chk("timed_out", 64'(timed_out), 64'(exp_to));
                chk("count_frozen", 64'(cycle_count), 64'(exp_cnt));
            end else if (phase == M_WAIT) begin
                chk("ready_wait", 64'(host_ready), 64'd0);
            end
            if (exp_start >= 0 && cyc >= exp_start && !dn)
                chk("count_run", 64'(cycle_count), 64'(cyc - exp_start));
            if (exp_start >= 0 && cyc == exp_start)
                chk("prog_address", 64'(prog_address), 64'(exp_pa));
        end
        rst_chk = 0;
        if (reset) begin
            rst_chk = 1;
            expq.delete();
            phase = M_LEN;
            exp_start = -1;
            exp_done = -1;
            exp_cnt = 0;
            exp_to = 0;
            exp_err = 0;
            exp_pa = 0;
        end else if (cyc >= 1) begin
            if (phase == M_WAIT && exp_done >= 0 && cyc >= exp_done)
                phase = M_LEN;
            if (halt_valid && phase == M_WAIT && exp_start >= 0 &&
                cyc > exp_start && cyc < exp_done) begin
                exp_done = cyc + 1;
                exp_cnt = cyc - exp_start;
                exp_to = 0;
            end
            if (host_valid && host_ready) begin
                case (phase)
                    M_LEN: begin
                        lenm = int'(host_data);
                        exp_start = -1;
                        exp_to = 0;
                        if (host_data == 0 || host_data > 32'd4096) begin
                            exp_err = 1;
                            exp_done = cyc + 1;
                        end else begin
                            exp_err = 0;
                            exp_done = -1;
                            phase = M_HDR;
                        end
                    end
                    M_HDR: begin
                        basem = int'(host_data[13:2]);
                        exp_pa = host_data[19:0];
                        idxm = 0;
                        phase = M_DATA;
                    end
                    M_DATA: begin
                        expq.push_back('{cyc + 1,
                                         12'((basem + idxm) % 4096),
                                         host_data});
                        idxm++;
                        if (idxm == lenm) begin
                            phase = M_WAIT;
                            exp_start = cyc + RST + 2;
                            exp_done = exp_start + TMO;
                            exp_cnt = TMO - 1;
                            exp_to = 1;
                        end
                    end
                    default: chk("ready_extra", 64'd1, 64'd0);
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] w);
        int t;
        host_data = w;
        host_valid = 1;
        for (t = 0; t < 100; t++) begin
            @(negedge clock);
            if (host_ready) break;
        end
        if (t == 100) chk("send_timeout", 64'd0, 64'd1);
        step();
        host_valid = 0;
    endtask

    task automatic halt_at(input int t);
        int n = 0;
        while (cyc < t && n < 1000) begin
            step();
            n++;
        end
        chk("halt_sched", 64'(cyc), 64'(t));
        halt_valid = 1;
        step();
        halt_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        chk("wait_done", 64'(done), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        host_valid = 0;
        host_data = 0;
        halt_valid = 0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        step();
        chk("lit_reset_core", 64'(core_reset), 64'd1);

        // normal load and halt
        wr_log.delete();
        send(32'd3);
        send(32'h10);
        send(32'hAAAA0001);
        send(32'hAAAA0002);
        send(32'hAAAA0003);
        halt_at(exp_start + 20);
        wait_done();
        idle(2);
        chk("lit_log_n", 64'(wr_log.size()), 64'd3);
        chk("lit_log", 64'({wr_log[0], wr_log[1], wr_log[2]}),
            64'({12'h004, 12'h005, 12'h006}));
        chk("lit_start_gap", 64'(seen_start - last_wr), 64'd11);
        chk("lit_count20", 64'(cycle_count), 64'd20);
        chk("lit_to0", 64'(timed_out), 64'd0);
        chk("lit_pa", 64'(prog_address), 64'h10);

        // backpressure and address wrap, restarted from DONE
        wr_log.delete();
        send(32'd4);
        chk("lit_done_clr", 64'({done, timed_out, error}), 64'd0);
        send(32'h3FF8);
        for (int i = 0; i < 4; i++) begin
            send(32'h5500_0000 + 32'(i));
            idle(1);
        end
        halt_at(exp_start + 5);
        wait_done();
        chk("lit_wrap_n", 64'(wr_log.size()), 64'd4);
        chk("lit_wrap",
            64'({wr_log[0], wr_log[1], wr_log[2], wr_log[3]}),
            64'({12'hFFE, 12'hFFF, 12'h000, 12'h001}));
        chk("lit_count5", 64'(cycle_count), 64'd5);

        // timeout, late halt ignored
        send(32'd1);
        send(32'h0);
        send(32'h1234_5678);
        wait_done();
        idle(3);
        halt_valid = 1;
        step();
        halt_valid = 0;
        idle(3);
        chk("lit_to_count", 64'(cycle_count), 64'd49);
        chk("lit_to1", 64'(timed_out), 64'd1);

        // halt on the timeout cycle
        send(32'd1);
        send(32'h8);
        send(32'hCAFE_0001);
        halt_at(exp_start + TMO - 1);
        wait_done();
        chk("lit_tie_to", 64'(timed_out), 64'd0);
        chk("lit_tie_cnt", 64'(cycle_count), 64'd49);

        // bad headers
        wr_log.delete();
        send(32'd0);
        idle(2);
        chk("lit_len0", 64'({error, done, core_reset}), 64'b111);
        send(32'd4097);
        idle(2);
        chk("lit_len4097", 64'({error, done}), 64'b11);
        chk("lit_bad_nowr", 64'(wr_log.size()), 64'd0);

        // reset during load, then a full run
        send(32'd5);
        send(32'h20);
        send(32'h0BAD_0001);
        send(32'h0BAD_0002);
        reset = 1;
        step();
        reset = 0;
        step();
        chk("lit_rst_idle", 64'({busy, done, core_reset}), 64'b001);
        wr_log.delete();
        send(32'd2);
        send(32'h40);
        send(32'h600D_0001);
        send(32'h600D_0002);
        halt_at(exp_start + 3);
        wait_done();
        chk("lit_rerun_log", 64'({wr_log[0], wr_log[1]}),
            64'({12'h010, 12'h011}));
        chk("lit_count3", 64'(cycle_count), 64'd3);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_boot_sequencer.md
Name: core_boot_sequencer

Overview:
- Sequences one bring-up run of the RISC-V core: receives a program image over a valid/ready word stream, writes it through the core's ISP port, holds the core in reset, pulses start with the boot address, then times the run until halt or timeout.
- Sits between a host/loader (UART bridge or bench) and the core's `isp_*`, `reset`, `start` and `prog_address` inputs.
- Replaces hand-timed `#delay` reset/start sequencing with a deterministic controller.

Parameters:
DATA_WIDTH, 32, width of ISP data and host words
ADDRESS_BITS, 12, ISP word-address width; program memory holds 2^ADDRESS_BITS words
RESET_CYCLES, 10, cycles `core_reset` is held high after the image is loaded (must be ≥1)
TIMEOUT_CYCLES, 100000, maximum run cycles before the run is abandoned (must be ≥1)

Ports:
clock  in  1  single system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset of this block
host_data  in  DATA_WIDTH  stream word (length, header, then program words)
host_valid  in  1  host_data valid
host_ready  out  1  sequencer accepts host_data this cycle
isp_write  out  1  ISP write strobe to core
isp_address  out  ADDRESS_BITS  ISP word address
isp_data  out  DATA_WIDTH  ISP write data
core_reset  out  1  reset to core
core_start  out  1  one-cycle start pulse to core
prog_address  out  20  boot address presented with core_start
halt_valid  in  1  core signals program end (decoded from to_peripheral/to_peripheral_valid upstream)
busy  out  1  run sequence in progress (not IDLE/DONE)
done  out  1  run finished (halt, timeout or error); sticky until next run
timed_out  out  1  run ended by timeout
error  out  1  bad header (length 0 or > 2^ADDRESS_BITS)
cycle_count  out  32  cycles from core_start to end of run

Behaviour:
- Reset values: `host_ready`=0, `isp_write`=0, `isp_address`=0, `isp_data`=0, `core_reset`=1, `core_start`=0, `prog_address`=0, `busy`=0, `done`=0, `timed_out`=0, `error`=0, `cycle_count`=0. State=IDLE.
- A handshake occurs when `host_valid` and `host_ready` are both high on a rising edge.
- `host_ready`=1 only in IDLE, HDR, LOAD and DONE. It is registered: it goes high the cycle after entering one of these states.
- IDLE: `core_reset`=1.
  - Handshake → latch LEN=host_data.
  - If LEN==0 or LEN > 2^ADDRESS_BITS → DONE with `error`=1 and `done`=1.
  - Otherwise → HDR, with `busy`=1.
- HDR: handshake → `prog_address`=host_data[19:0], base word address=host_data[ADDRESS_BITS+1:2], index=0 → LOAD.
- LOAD: each handshake produces one write on the next cycle:
  - `isp_write`=1 for exactly one cycle.
  - `isp_address`=(base+index) mod 2^ADDRESS_BITS, so the address wraps at the memory top.
  - `isp_data`=host_data.
  - After the LEN-th word → RST_HOLD.
  - Gaps in `host_valid` stall LOAD indefinitely; no timeout applies while loading.
- RST_HOLD: `core_reset`=1 for exactly RESET_CYCLES cycles, counted from the cycle after the last ISP write → START.
- START: `core_reset`=0, `core_start`=1 for exactly one cycle, `cycle_count` cleared to 0 → RUN.
- RUN: `cycle_count` increments by 1 every cycle.
  - `halt_valid`=1 → DONE, `done`=1.
  - `cycle_count`==TIMEOUT_CYCLES-1 with no halt → DONE, `done`=1, `timed_out`=1.
  - Halt and timeout in the same cycle: halt wins, so `timed_out`=0.
  - `halt_valid` outside RUN is ignored.
- DONE: `busy`=0, `core_reset` stays 0 so the register file remains inspectable. `cycle_count` is frozen.
  - A handshake in DONE is a new LEN word. It clears `done`, `timed_out` and `error`, asserts `core_reset`=1, and is validated exactly as in IDLE.
- `reset` asserted mid-operation (any state) → all outputs take their reset values on the next edge, with no partial ISP write. An in-flight host word is dropped.
- `cycle_count` saturates; it never wraps.

Test Plan:
- Normal load, LEN=3, header=0x00000010: words 0xAAAA0001/2/3 → ISP writes at addresses 4,5,6 on the cycles after each handshake. `core_reset` falls 10 cycles after the last write. `core_start` is high for one cycle with `prog_address`=0x00010. `halt_valid` pulsed 20 cycles after start → `done`=1, `cycle_count`=20, `timed_out`=0.
- Backpressure and wrap: LEN=4, base word 0xFFE, `host_valid` toggling 1/0 → writes at 0xFFE, 0xFFF, 0x000, 0x001, one per accepted word, none duplicated or lost.
- Timeout with TIMEOUT_CYCLES=50 and no halt → `done`=1 and `timed_out`=1 at cycle 50 after start, `cycle_count`=49 frozen. A halt arriving later is ignored.
- Simultaneous halt and timeout on the final cycle → `timed_out`=0, `done`=1.
- Bad headers: LEN=0 → `error`=1, `done`=1, no ISP writes, no `core_start`. LEN=4097 with ADDRESS_BITS=12 → same.
- Reset asserted after 2 of 5 load words → all outputs return to reset values, state IDLE. A following full run completes normally. A new LEN in DONE restarts the run and clears the flags.
